// File: rtl/mlp_layer_sequencer.sv
// Address/strobe sequencer for one fully-connected MLP layer: walks every output neuron over
// every input neuron and emits the MAC enable plus the accumulator flush pulse.
module mlp_layer_sequencer #(
  parameter int unsigned NUM_INPUTS  = 64,
  parameter int unsigned NUM_OUTPUTS = 16,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mac_en_o,
  output logic [11:0]       in_addr_o,
  output logic [ADDR_W-1:0] weight_addr_o,
  output logic              reset_mult_acc_o,
  output logic [11:0]       out_neuron_addr_o
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  localparam logic [11:0] InLast  = 12'(NUM_INPUTS - 1);
  localparam logic [11:0] OutLast = 12'(NUM_OUTPUTS - 1);

  state_e            st_q, st_d;
  logic [11:0]       in_q, in_d;
  logic [11:0]       out_q, out_d;
  logic [ADDR_W-1:0] w_q, w_d;
  logic              mac_q, mac_d;
  logic              rma_q, rma_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Registers hold the operation presented this cycle; a stall re-presents the same
  // addresses with the strobes cleared and leaves the sequencing position untouched.
  always_comb begin
    st_d   = st_q;
    in_d   = in_q;
    out_d  = out_q;
    w_d    = w_q;
    mac_d  = 1'b0;
    rma_d  = 1'b0;
    done_d = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (start_i) begin
          st_d  = StRun;
          in_d  = '0;
          out_d = '0;
          w_d   = '0;
          mac_d = 1'b1;
        end
      end
      StRun: begin
        if (!stall_i) begin
          w_d = w_q + ADDR_W'(1);
          if (in_q == InLast) begin
            st_d  = StFlush;
            rma_d = 1'b1;
          end else begin
            in_d  = in_q + 12'd1;
            mac_d = 1'b1;
          end
        end
      end
      StFlush: begin
        if (!stall_i) begin
          if (out_q == OutLast) begin
            st_d   = StDone;
            done_d = 1'b1;
          end else begin
            st_d  = StRun;
            out_d = out_q + 12'd1;
            in_d  = '0;
            mac_d = 1'b1;
          end
        end
      end
      StDone: begin
        st_d = StIdle;
      end
      default: begin
        st_d = StIdle;
      end
    endcase
    busy_d = (st_d == StRun) || (st_d == StFlush);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= StIdle;
      in_q   <= '0;
      out_q  <= '0;
      w_q    <= '0;
      mac_q  <= 1'b0;
      rma_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      in_q   <= in_d;
      out_q  <= out_d;
      w_q    <= w_d;
      mac_q  <= mac_d;
      rma_q  <= rma_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign mac_en_o          = mac_q;
  assign in_addr_o         = in_q;
  assign weight_addr_o     = w_q;
  assign reset_mult_acc_o  = rma_q;
  assign out_neuron_addr_o = out_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench: per-cycle expected outputs are queued when a pass is launched and popped
// at each falling edge for comparison against two sequencer instances.
module tb_mlp_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, stall_a, start_b, stall_b;
  logic        busy_a, done_a, mac_a, rma_a, busy_b, done_b, mac_b, rma_b;
  logic [11:0] in_a, out_a, w_a, in_b, out_b, w_b;

  mlp_layer_sequencer #(.NUM_INPUTS(4), .NUM_OUTPUTS(3), .ADDR_W(12)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .stall_i(stall_a),
    .busy_o(busy_a), .done_o(done_a), .mac_en_o(mac_a), .in_addr_o(in_a),
    .weight_addr_o(w_a), .reset_mult_acc_o(rma_a), .out_neuron_addr_o(out_a)
  );

  mlp_layer_sequencer #(.NUM_INPUTS(1), .NUM_OUTPUTS(2), .ADDR_W(12)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .stall_i(stall_b),
    .busy_o(busy_b), .done_o(done_b), .mac_en_o(mac_b), .in_addr_o(in_b),
    .weight_addr_o(w_b), .reset_mult_acc_o(rma_b), .out_neuron_addr_o(out_b)
  );

  typedef struct {
    bit mac;
    bit rma;
    bit done;
    bit busy;
    bit zaddr;
    int in_i;
    int w;
    int out;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input bit sel, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".mac_en"}, 32'(sel ? mac_b : mac_a), 32'(e.mac));
    chk({tag, ".reset_mult_acc"}, 32'(sel ? rma_b : rma_a), 32'(e.rma));
    chk({tag, ".done"}, 32'(sel ? done_b : done_a), 32'(e.done));
    chk({tag, ".busy"}, 32'(sel ? busy_b : busy_a), 32'(e.busy));
    chk({tag, ".out_neuron_addr"}, 32'(sel ? out_b : out_a), e.out);
    if (e.mac || e.zaddr) begin
      chk({tag, ".in_addr"}, 32'(sel ? in_b : in_a), e.in_i);
      chk({tag, ".weight_addr"}, 32'(sel ? w_b : w_a), e.w);
    end
  endtask

  task automatic drive(input bit sel, input bit st, input bit sl);
    if (sel) begin
      start_b = st;
      stall_b = sl;
    end else begin
      start_a = st;
      stall_a = sl;
    end
  endtask

  // Idle cycles: strobes low, stall toggling, out_neuron_addr holding out_exp.
  task automatic idle_steps(input bit sel, input int n, input bit st, input int out_exp,
                            input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '{mac: 0, rma: 0, done: 0, busy: 0, zaddr: 0, in_i: 0, w: 0, out: out_exp};
      sb.push_back(e);
      drive(sel, st, i[0]);
      @(negedge clk);
      check_cycle(sel, tag);
    end
    drive(sel, 1'b0, 1'b0);
  endtask

  // Launch a pass at the next edge; bub[c] high means the stall is sampled at the edge that
  // opens cycle c, turning that cycle into a bubble when the sequencer is busy.
  task automatic run_pass(input bit sel, input int ni, input int no, input logic [63:0] bub,
                          input bit hold, input int ncyc, input string tag);
    exp_t ops[$];
    exp_t e, prev;
    int   idx;
    int   len;
    for (int k = 0; k < no; k++) begin
      for (int i = 0; i < ni; i++) begin
        e = '{mac: 1, rma: 0, done: 0, busy: 1, zaddr: 0, in_i: i, w: k * ni + i, out: k};
        ops.push_back(e);
      end
      e = '{mac: 0, rma: 1, done: 0, busy: 1, zaddr: 0, in_i: 0, w: 0, out: k};
      ops.push_back(e);
    end
    e = '{mac: 0, rma: 0, done: 1, busy: 0, zaddr: 0, in_i: 0, w: 0, out: no - 1};
    ops.push_back(e);
    prev = '{mac: 0, rma: 0, done: 0, busy: 0, zaddr: 0, in_i: 0, w: 0, out: 0};
    idx  = 0;
    len  = 0;
    while (idx < ops.size()) begin
      if (bub[len + 1] && prev.busy) begin
        e = '{mac: 0, rma: 0, done: 0, busy: 1, zaddr: 0, in_i: 0, w: 0, out: prev.out};
      end else begin
        e = ops[idx];
        idx++;
      end
      sb.push_back(e);
      prev = e;
      len++;
    end
    for (int c = 1; c <= len && c <= ncyc; c++) begin
      drive(sel, (c == 1) || hold, bub[c]);
      @(negedge clk);
      check_cycle(sel, $sformatf("%s.c%0d", tag, c));
    end
    drive(sel, hold, 1'b0);
    sb.delete();
  endtask

  initial begin
    exp_t z;
    rst_n   = 1'b0;
    start_a = 1'b0;
    stall_a = 1'b0;
    start_b = 1'b0;
    stall_b = 1'b0;
    repeat (2) @(negedge clk);
    z = '{mac: 0, rma: 0, done: 0, busy: 0, zaddr: 1, in_i: 0, w: 0, out: 0};
    sb.push_back(z);
    check_cycle(1'b0, "reset_state");
    rst_n = 1'b1;

    idle_steps(1'b0, 8, 1'b0, 0, "idle_a");
    idle_steps(1'b1, 3, 1'b0, 0, "idle_b");

    run_pass(1'b0, 4, 3, 64'd0, 1'b0, 99, "basic");
    idle_steps(1'b0, 1, 1'b0, 2, "post_basic");

    run_pass(1'b0, 4, 3, (64'd1 << 3) | (64'd1 << 5), 1'b0, 99, "stall");
    idle_steps(1'b0, 1, 1'b0, 2, "post_stall");

    // start held high: done in cycle 16, idle in 17, next pass starts in 18
    run_pass(1'b0, 4, 3, 64'd0, 1'b1, 99, "hold1");
    idle_steps(1'b0, 1, 1'b1, 2, "hold_gap");
    run_pass(1'b0, 4, 3, 64'd0, 1'b0, 99, "hold2");
    idle_steps(1'b0, 1, 1'b0, 2, "post_hold");

    run_pass(1'b0, 4, 3, 64'd0, 1'b0, 7, "pre_reset");
    rst_n = 1'b0;
    #1;
    sb.push_back(z);
    check_cycle(1'b0, "async_reset");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sb.push_back(z);
      check_cycle(1'b0, "in_reset");
    end
    rst_n = 1'b1;
    idle_steps(1'b0, 3, 1'b0, 0, "post_reset_idle");
    run_pass(1'b0, 4, 3, 64'd0, 1'b0, 99, "restart");

    run_pass(1'b1, 1, 2, 64'd0, 1'b0, 99, "ni1");
    idle_steps(1'b1, 2, 1'b0, 1, "post_ni1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_layer_sequencer.md
# mlp_layer_sequencer

Control sequencer for one fully-connected MLP layer. It drives the input-neuron and weight-memory read addresses and a MAC-enable strobe. It emits the `reset_mult_acc` / `out_neuron_addr` pair that the one-cycle pipeline buffer forwards to the multiply-accumulate and output-writeback stage. It is the originating end of that interface and walks every output neuron over every input neuron.

## Interface

- `NUM_INPUTS`, default 64: input neurons per output neuron; must be ≥ 1.
- `NUM_OUTPUTS`, default 16: output neurons in the layer; must be ≥ 1 and ≤ 4096.
- `ADDR_W`, default 12: weight address width; NUM_INPUTS*NUM_OUTPUTS ≤ 2^ADDR_W.
- `clk`  in  1  single clock; all flops on rising edge.
- `reset`  in  1  asynchronous, active-low; when 0, all state and outputs clear immediately.
- `start`  in  1  begin a layer pass; sampled only in IDLE.
- `stall`  in  1  freeze sequencing this cycle (downstream back-pressure).
- `busy`  out  1  high in RUN and FLUSH.
- `done`  out  1  one-cycle pulse after the final flush.
- `mac_en`  out  1  current `in_addr`/`weight_addr` are a valid MAC operand pair.
- `in_addr`  out  12  input-neuron index, 0..NUM_INPUTS-1.
- `weight_addr`  out  ADDR_W  weight index = out_idx*NUM_INPUTS + in_idx.
- `reset_mult_acc`  out  1  flush pulse: accumulator for `out_neuron_addr` is complete; downstream writes it back and clears.
- `out_neuron_addr`  out  12  index of the output neuron currently being accumulated/flushed.

## Operation

- All outputs are driven directly from flops. Reset value of every output is 0; the state resets to IDLE.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: all strobes low. `start`=1 → RUN with in_idx=0, out_idx=0, weight counter=0.
- RUN: `mac_en`=1 and `in_addr`=in_idx, `weight_addr`=weight counter.
  - Each un-stalled cycle, in_idx and the weight counter both increment by 1. The weight counter is a running counter, not a multiplier.
  - When in_idx==NUM_INPUTS-1, the state goes to FLUSH instead of incrementing in_idx.
- FLUSH: `mac_en`=0, `reset_mult_acc`=1, `out_neuron_addr`=out_idx. Exactly one un-stalled cycle per output neuron.
  - If out_idx==NUM_OUTPUTS-1 → DONE.
  - Otherwise out_idx+1, in_idx=0 → RUN. The weight counter continues contiguously.
- DONE: `done`=1 for one cycle, then → IDLE. `start` is ignored in DONE.
- `stall`=1 in RUN or FLUSH: the state and all counters hold, and `mac_en` and `reset_mult_acc` are forced 0 that cycle. Addresses hold their values. `stall` has no effect in IDLE or DONE.
- `start` while `busy` is ignored; there is no restart or queueing.
- `out_neuron_addr` tracks out_idx at all times. It is meaningful downstream only when qualified by `reset_mult_acc`.
- NUM_INPUTS=1: each neuron is one RUN cycle followed by one FLUSH cycle.
- Asynchronous reset mid-pass: outputs drop to 0 without waiting for a clock edge. No `done` is produced. The pass is abandoned, and a new `start` after reset release begins from neuron 0.

## Timing

- `start` sampled at edge 0 → the first `mac_en` (in_addr 0, weight_addr 0) is visible in cycle 1.
- Unstalled pass, neuron k:
  - RUN occupies cycles k*(NUM_INPUTS+1)+1 .. k*(NUM_INPUTS+1)+NUM_INPUTS.
  - FLUSH occupies cycle (k+1)*(NUM_INPUTS+1).
- `done` appears in cycle NUM_OUTPUTS*(NUM_INPUTS+1)+1. `busy` is low in that cycle.
- Each stalled cycle adds exactly one cycle to all subsequent events.
- The earliest accepted re-`start` is sampled in the cycle after `done`.
- Downstream sees `reset_mult_acc`/`out_neuron_addr` one cycle later through the pipeline buffer. That buffer delay is matched by the one-cycle weight-memory read latency, so the sequencer adds no compensation of its own.

## Test plan

- Basic pass, NUM_INPUTS=4, NUM_OUTPUTS=3, start at edge 0:
  - `mac_en` high in cycles 1-4, 6-9 and 11-14, with `weight_addr` 0..11 contiguous and `in_addr` cycling 0..3.
  - `reset_mult_acc` in cycles 5, 10 and 15 with `out_neuron_addr` 0, 1 and 2.
  - `done` in cycle 16 only.
- Stall, same config: `stall`=1 in cycles 3 and 5 → `mac_en` is low in 3 and `reset_mult_acc` is low in 5. The sequence resumes with the same addresses; flushes land in cycles 7, 12 and 17, and `done` in cycle 18.
- `start` held high throughout → exactly one pass per IDLE entry. The second pass's first `mac_en` appears in cycle 18 (start re-sampled at edge 17).
- Reset asserted (`reset`=0) mid-RUN of neuron 1 → all outputs 0 before the next edge and no `done`. After release, `start` restarts at `weight_addr` 0 and `out_neuron_addr` 0.
- NUM_INPUTS=1, NUM_OUTPUTS=2 → `mac_en` in cycles 1 and 3 (`weight_addr` 0 and 1), `reset_mult_acc` in cycles 2 and 4, `done` in cycle 5.
- Post-reset idle with `start`=0 → every output stays 0 indefinitely, and toggling `stall` changes nothing.
